// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Brief    : Shared types and constants for the iterative divider.
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

  // Default operand width of the Execute-stage divider
  localparam int DIV_WIDTH = 32;

  // Divide-by-zero quotient is all ones; the bit form lets any width use it
  localparam logic                 DIV0_QUOT_BIT = 1'b1;
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOT     = {DIV_WIDTH{DIV0_QUOT_BIT}};

  // Divider sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Brief    : One combinational restoring-division step.
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,   // partial remainder
  input  logic [WIDTH-1:0] div_i,   // divisor magnitude
  input  logic             bit_i,   // next dividend bit, MSB first
  output logic [WIDTH:0]   rem_o,   // updated partial remainder
  output logic             q_o      // quotient bit produced this step
);

  logic [WIDTH+1:0] w_trial;
  logic [WIDTH+1:0] w_diff;

  // Shift in the dividend bit, trial-subtract, restore when it goes negative
  always_comb begin
    w_trial = {rem_i, bit_i};
    w_diff  = w_trial - {2'b00, div_i};
    q_o     = ~w_diff[WIDTH+1];
    rem_o   = q_o ? w_diff[WIDTH:0] : w_trial[WIDTH:0];
  end

endmodule : div_step
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Brief    : Iterative radix-2 signed/unsigned divider for DIV/DIVU with
//            pipeline stall, hold and flush handling.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               cancel_i,
  input  logic               hold_i,
  output logic               stall_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] c_last_step = CNT_W'(WIDTH - 1);

  div_state_e         state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH:0]     rem_q,    rem_d;
  logic [WIDTH-1:0]   dvd_q,    dvd_d;    // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]   div_q,    div_d;
  logic               qsign_q,  qsign_d;
  logic               rsign_q,  rsign_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]     w_step_rem;
  logic               w_step_q;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic               unused_rem_msb;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .div_i (div_q),
    .bit_i (dvd_q[WIDTH-1]),
    .rem_o (w_step_rem),
    .q_o   (w_step_q)
  );

  // The final remainder is below the divisor, so its top bit is always zero
  assign unused_rem_msb = rem_q[WIDTH];

  // Operand magnitudes and sign-corrected results; negation truncates, which
  // makes the most-negative / -1 overflow come out right without a special case
  always_comb begin
    w_a_abs    = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    w_b_abs    = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
    w_quot_fix = qsign_q ? -dvd_q : dvd_q;
    w_rem_fix  = rsign_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end

  // State register and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      div_q    <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      div_q    <= div_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      result_q <= result_d;
    end
  end

  // Next-state and datapath update; a flush abandons everything else
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    div_d    = div_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    result_d = result_q;

    if (cancel_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            dvd_d   = w_a_abs;
            div_d   = w_b_abs;
            rem_d   = '0;
            cnt_d   = '0;
            qsign_d = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            rsign_d = signed_i & a_i[WIDTH-1];
            if (b_i == '0) begin
              result_d = {a_i, {WIDTH{DIV0_QUOT_BIT}}};
              state_d  = ST_DONE;
            end else begin
              state_d  = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          rem_d = w_step_rem;
          dvd_d = {dvd_q[WIDTH-2:0], w_step_q};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == c_last_step) begin
            state_d = ST_FIX;
          end
        end
        ST_FIX: begin
          result_d = {w_rem_fix, w_quot_fix};
          state_d  = ST_DONE;
        end
        ST_DONE: begin
          if (!hold_i) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign stall_o  = start_i & ~cancel_i & (state_q != ST_DONE);
  assign ready_o  = (state_q == ST_DONE);
  assign result_o = result_q;

endmodule : div_iter
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_iter
// Brief    : Self-checking bench for div_iter: directed table, random
//            vectors against an arithmetic model, and flush/reset/hold cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_iter;

  logic        clk;
  logic        resetn;
  logic        start_i;
  logic        signed_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        cancel_i;
  logic        hold_i;
  logic        stall_o;
  logic        ready_o;
  logic [63:0] result_o;

  int checks = 0;
  int errors = 0;

  div_iter #(.WIDTH(32)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start_i  (start_i),
    .signed_i (signed_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .cancel_i (cancel_i),
    .hold_i   (hold_i),
    .stall_o  (stall_o),
    .ready_o  (ready_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          stalls;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: DIV/DIVU semantics via 64-bit integer arithmetic
  function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    sa = sg ? longint'($signed(a)) : longint'(a);
    sb = sg ? longint'($signed(b)) : longint'(b);
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one divide (start left high afterwards) and check result and stall count
  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int exp_stalls, input string nm);
    int stalls;
    int cyc;
    @(negedge clk);
    start_i  = 1'b1;
    signed_i = sg;
    a_i      = a;
    b_i      = b;
    stalls   = 0;
    cyc      = 0;
    #1;
    while (!ready_o && cyc < 100) begin
      if (stall_o) stalls++;
      @(negedge clk);
      #1;
      cyc++;
    end
    if (!ready_o) begin
      errors++;
      checks++;
      $display("FAIL %s timeout actual=not-ready required=ready", nm);
    end else begin
      chk({nm, " result"}, result_o, exp);
      chk({nm, " stalls"}, 64'(stalls), 64'(exp_stalls));
      chk({nm, " stall_at_done"}, {63'd0, stall_o}, 64'd0);
    end
  endtask

  vec_t vecs[8];

  initial begin
    logic [63:0] last_exp;
    logic [31:0] ra, rb;
    logic        rs;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        {32'h0000_0002, 32'h0000_000E}, 34};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34};
    vecs[2] = '{1'b1, 32'h0000_0007,  32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 34};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 34};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'h0000_0001, {32'h0000_0000, 32'hFFFF_FFFF}, 34};
    vecs[5] = '{1'b0, 32'h1234_5678,  32'h0000_0000, {32'h1234_5678, 32'hFFFF_FFFF}, 1};
    vecs[6] = '{1'b0, 32'd5,          32'd9,        {32'h0000_0005, 32'h0000_0000}, 34};
    vecs[7] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'h0000_000E}, 34};

    resetn   = 1'b0;
    start_i  = 1'b0;
    signed_i = 1'b0;
    a_i      = '0;
    b_i      = '0;
    cancel_i = 1'b0;
    hold_i   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset ready", {63'd0, ready_o}, 64'd0);
    chk("reset stall", {63'd0, stall_o}, 64'd0);
    chk("reset result", result_o, 64'd0);
    resetn = 1'b1;

    // Directed table, issued back to back
    for (int i = 0; i < 8; i++) begin
      do_div(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stalls,
             $sformatf("vec%0d", i));
    end
    last_exp = vecs[7].exp;

    // Flush in RUN cycle 10: stall drops immediately, result retained, not valid
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd12345; b_i = 32'd3;
    repeat (10) @(negedge clk);
    cancel_i = 1'b1;
    #1;
    chk("cancel stall", {63'd0, stall_o}, 64'd0);
    @(negedge clk);
    cancel_i = 1'b0;
    start_i  = 1'b0;
    #1;
    chk("cancel ready", {63'd0, ready_o}, 64'd0);
    chk("cancel result kept", result_o, last_exp);
    do_div(1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 34, "after_cancel");

    // Reset mid-RUN clears outputs immediately
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b1; a_i = 32'hFFFF_0000; b_i = 32'd77;
    repeat (5) @(negedge clk);
    start_i = 1'b0;
    resetn  = 1'b0;
    #1;
    chk("midrun reset ready", {63'd0, ready_o}, 64'd0);
    chk("midrun reset stall", {63'd0, stall_o}, 64'd0);
    chk("midrun reset result", result_o, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    do_div(1'b0, 32'd77, 32'd7, {32'd0, 32'd11}, 34, "after_reset");

    // Hold in DONE: result frozen, no stall, no restart
    do_div(1'b0, 32'd50, 32'd6, {32'd2, 32'd8}, 34, "pre_hold");
    hold_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("hold%0d ready", i), {63'd0, ready_o}, 64'd1);
      chk($sformatf("hold%0d stall", i), {63'd0, stall_o}, 64'd0);
      chk($sformatf("hold%0d result", i), result_o, {32'd2, 32'd8});
    end
    hold_i = 1'b0;
    do_div(1'b1, 32'hFFFF_FC18, 32'd3, model(1'b1, 32'hFFFF_FC18, 32'd3), 34, "after_hold");

    // Random vectors against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 15));
        3:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      do_div(rs, ra, rb, model(rs, ra, rb), (rb == 32'd0) ? 1 : 34,
             $sformatf("rnd%0d s=%0d a=%h b=%h", i, rs, ra, rb));
    end

    start_i = 1'b0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_div_iter
`default_nettype wire
